// File: rtl/cp0_unit.sv
// MIPS coprocessor 0: status/cause/EPC state, interrupt prioritisation and exception/eret redirect.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_unit #(
   parameter int unsigned HW_INT_W   = 6,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
   parameter logic [31:0] BEV_VECTOR = 32'hBFC0_0380,
   parameter int unsigned COUNT_DIV  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          reg_num,
   input  logic [2:0]          reg_sel,
   input  logic [31:0]         wdata,
   input  logic                we,
   output logic [31:0]         rdata,
   input  logic [HW_INT_W-1:0] hw_int,
   input  logic                exc_req,
   input  logic [4:0]          exc_code,
   input  logic [31:0]         exc_pc,
   input  logic                exc_bd,
   input  logic [31:0]         exc_badvaddr,
   input  logic                eret,
   output logic                int_pending,
   output logic                redirect_valid,
   output logic [31:0]         redirect_pc,
   output logic                status_exl
);

   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_STATUS   = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;
   localparam logic [4:0]  REG_ERROREPC = 5'd30;
   localparam logic [31:0] STATUS_MASK  = 32'h0040_FF17;
   localparam logic [31:0] STATUS_RST   = 32'h0040_0004;

   generate
      if (HW_INT_W < 1 || HW_INT_W > 6 || COUNT_DIV < 1) begin : g_bad_param
         $error("cp0_unit: HW_INT_W must be 1..6 and COUNT_DIV >= 1");
      end
   endgenerate

   logic [31:0] r_status;
   logic [31:0] r_epc;
   logic [31:0] r_errorepc;
   logic [31:0] r_badvaddr;
   logic        r_cause_bd;
   logic [4:0]  r_exc_code;
   logic [1:0]  r_sw_ip;
   logic [5:0]  r_hw_ip;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   logic [5:0]  w_hw_ip;
   logic [7:0]  w_ip;
   logic        w_ti;
   logic        w_sel0;
   logic        w_wr;
   logic        w_ie;
   logic        w_exl;
   logic        w_erl;
   logic        w_bev;
   logic [31:0] w_cause;

   assign w_sel0 = (reg_sel == 3'd0);
   // mtc0 only lands when no exception or eret claims the same cycle
   assign w_wr   = we & w_sel0 & ~exc_req & ~eret;
   assign w_ie   = r_status[0];
   assign w_exl  = r_status[1];
   assign w_erl  = r_status[2];
   assign w_bev  = r_status[22];

   always_comb begin
      w_hw_ip                 = '0;
      w_hw_ip[HW_INT_W-1:0]   = hw_int;
   end

   assign w_ip        = {r_hw_ip[5] | w_ti, r_hw_ip[4:0], r_sw_ip};
   assign w_cause     = {r_cause_bd, w_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};
   assign int_pending = w_ie & ~w_exl & ~w_erl & (|(w_ip & r_status[15:8]));
   assign status_exl  = w_exl;

`ifdef CP0_TIMER_EN
   localparam logic [4:0]  REG_COUNT   = 5'd9;
   localparam logic [4:0]  REG_COMPARE = 5'd11;
   localparam int unsigned PRESC_W     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [PRESC_W-1:0] r_presc;
   logic [31:0]        r_count;
   logic [31:0]        r_compare;
   logic               r_ti;
   logic               w_tick;
   logic               w_cnt_wr;
   logic               w_cmp_wr;
   logic [31:0]        w_count_inc;

   assign w_tick      = (r_presc == PRESC_W'(COUNT_DIV - 1));
   assign w_cnt_wr    = w_wr & (reg_num == REG_COUNT);
   assign w_cmp_wr    = w_wr & (reg_num == REG_COMPARE);
   assign w_count_inc = r_count + 32'd1;
   assign w_ti        = r_ti;

   // Prescaled Count with sticky compare-match flag; a Compare write clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc   <= '0;
         r_count   <= '0;
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else begin
         if (w_cnt_wr) begin
            r_count <= wdata;
            r_presc <= '0;
         end else if (w_tick) begin
            r_presc <= '0;
            r_count <= w_count_inc;
         end else begin
            r_presc <= r_presc + PRESC_W'(1);
         end
         if (w_cmp_wr) begin
            r_compare <= wdata;
            r_ti      <= 1'b0;
         end else if (!w_cnt_wr && w_tick && (w_count_inc == r_compare)) begin
            r_ti <= 1'b1;
         end
      end
   end
`else
   assign w_ti = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (w_sel0) begin
         case (reg_num)
            REG_BADVADDR: rdata = r_badvaddr;
`ifdef CP0_TIMER_EN
            REG_COUNT:    rdata = r_count;
            REG_COMPARE:  rdata = r_compare;
`endif
            REG_STATUS:   rdata = r_status;
            REG_CAUSE:    rdata = w_cause;
            REG_EPC:      rdata = r_epc;
            REG_ERROREPC: rdata = r_errorepc;
            default:      rdata = '0;
         endcase
      end
   end

   // Exception entry beats eret, which beats mtc0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_status         <= STATUS_RST;
         r_epc            <= '0;
         r_errorepc       <= '0;
         r_badvaddr       <= '0;
         r_cause_bd       <= 1'b0;
         r_exc_code       <= '0;
         r_sw_ip          <= '0;
         r_hw_ip          <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_hw_ip          <= w_hw_ip;
         r_redirect_valid <= exc_req | eret;
         if (exc_req) begin
            if (!w_exl) begin
               r_epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
               r_cause_bd <= exc_bd;
            end
            r_exc_code    <= exc_code;
            r_status[1]   <= 1'b1;
            if (exc_code == 5'd4 || exc_code == 5'd5) begin
               r_badvaddr <= exc_badvaddr;
            end
            r_redirect_pc <= w_bev ? BEV_VECTOR : EXC_VECTOR;
         end else if (eret) begin
            if (w_erl) begin
               r_status[2]   <= 1'b0;
               r_redirect_pc <= r_errorepc;
            end else begin
               r_status[1]   <= 1'b0;
               r_redirect_pc <= r_epc;
            end
         end else if (w_wr) begin
            case (reg_num)
               REG_BADVADDR: r_badvaddr <= wdata;
               REG_STATUS:   r_status   <= wdata & STATUS_MASK;
               REG_CAUSE:    r_sw_ip    <= wdata[9:8];
               REG_EPC:      r_epc      <= wdata;
               REG_ERROREPC: r_errorepc <= wdata;
               default:      ;
            endcase
         end
      end
   end

   // A reset cycle also masks a pulse already sitting in the register
   assign redirect_valid = r_redirect_valid & ~rst;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit; timer checks follow whether CP0_TIMER_EN is defined.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  reg_num;
   logic [2:0]  reg_sel;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic [5:0]  hw_int;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic        int_pending;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        status_exl;

   int n_vec = 0;
   int n_err = 0;

   cp0_unit #(
      .HW_INT_W   (6),
      .EXC_VECTOR (32'h8000_0180),
      .BEV_VECTOR (32'hBFC0_0380),
      .COUNT_DIV  (2)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .reg_num        (reg_num),
      .reg_sel        (reg_sel),
      .wdata          (wdata),
      .we             (we),
      .rdata          (rdata),
      .hw_int         (hw_int),
      .exc_req        (exc_req),
      .exc_code       (exc_code),
      .exc_pc         (exc_pc),
      .exc_bd         (exc_bd),
      .exc_badvaddr   (exc_badvaddr),
      .eret           (eret),
      .int_pending    (int_pending),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .status_exl     (status_exl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] r, output logic [31:0] v);
      reg_num = r;
      reg_sel = 3'd0;
      #1;
      v = rdata;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] v);
      reg_num = r;
      reg_sel = 3'd0;
      wdata   = v;
      we      = 1'b1;
      tick();
      we      = 1'b0;
   endtask

   task automatic do_exc(input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic [31:0] bad);
      exc_req      = 1'b1;
      exc_code     = code;
      exc_pc       = pc;
      exc_bd       = bd;
      exc_badvaddr = bad;
      tick();
      exc_req      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      int          cyc;
      logic        seen;

      rst = 1'b1; reg_num = '0; reg_sel = '0; wdata = '0; we = 1'b0;
      hw_int = '0; exc_req = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
      exc_badvaddr = '0; eret = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redir_pc", redirect_pc, 32'd0);
      chk("rst_int_pending", 32'(int_pending), 32'd0);
      rd(5'd12, v); chk("rst_status", v, 32'h0040_0004);
      rd(5'd13, v); chk("rst_cause", v, 32'd0);

      mtc0(5'd12, 32'h0000_0401);
      rd(5'd12, v); chk("status_wr", v, 32'h0000_0401);

      hw_int = 6'h01;
      #1 chk("int_same_cycle", 32'(int_pending), 32'd0);
      tick();
      chk("int_after_1", 32'(int_pending), 32'd1);

      do_exc(5'd0, 32'h8000_1000, 1'b0, 32'd0);
      chk("irq_redir_valid", 32'(redirect_valid), 32'd1);
      chk("irq_redir_pc", redirect_pc, 32'h8000_0180);
      chk("irq_exl", 32'(status_exl), 32'd1);
      chk("irq_int_masked", 32'(int_pending), 32'd0);
      rd(5'd14, v); chk("irq_epc", v, 32'h8000_1000);
      rd(5'd13, v); chk("irq_cause", v, 32'h0000_0400);
      tick();
      chk("irq_pulse_end", 32'(redirect_valid), 32'd0);

      hw_int = 6'h00;
      eret = 1'b1; we = 1'b1; reg_num = 5'd12; wdata = 32'd0;
      tick();
      eret = 1'b0; we = 1'b0;
      chk("eret_valid", 32'(redirect_valid), 32'd1);
      chk("eret_pc", redirect_pc, 32'h8000_1000);
      chk("eret_exl", 32'(status_exl), 32'd0);
      rd(5'd12, v); chk("eret_we_dropped", v, 32'h0000_0401);

      do_exc(5'd4, 32'h0000_0100, 1'b1, 32'h0000_0003);
      rd(5'd14, v); chk("bd_epc", v, 32'h0000_00FC);
      rd(5'd13, v); chk("bd_cause", v, 32'h8000_0010);
      rd(5'd8, v);  chk("bd_badvaddr", v, 32'h0000_0003);

      do_exc(5'd5, 32'h0000_0200, 1'b0, 32'h0000_0044);
      chk("nest_redir_pc", redirect_pc, 32'h8000_0180);
      rd(5'd14, v); chk("nest_epc", v, 32'h0000_00FC);
      rd(5'd13, v); chk("nest_cause", v, 32'h8000_0014);
      rd(5'd8, v);  chk("nest_badvaddr", v, 32'h0000_0044);

      mtc0(5'd30, 32'h0000_1234);
      mtc0(5'd12, 32'h0000_0006);
      eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("erl_eret_pc", redirect_pc, 32'h0000_1234);
      rd(5'd12, v); chk("erl_eret_status", v, 32'h0000_0002);

      mtc0(5'd12, 32'h0040_0000);
      do_exc(5'd8, 32'h0000_0400, 1'b0, 32'd0);
      chk("bev_redir_pc", redirect_pc, 32'hBFC0_0380);
      rd(5'd12, v); chk("bev_status", v, 32'h0040_0002);
      rd(5'd14, v); chk("bev_epc", v, 32'h0000_0400);
      rd(5'd13, v); chk("bev_cause", v, 32'h0000_0020);

      reg_num = 5'd12; reg_sel = 3'd1;
      #1 chk("sel1_read", rdata, 32'd0);
      we = 1'b1; wdata = 32'hFFFF_FFFF;
      tick();
      we = 1'b0;
      rd(5'd12, v); chk("sel1_wr_ignored", v, 32'h0040_0002);
      mtc0(5'd15, 32'hDEAD_BEEF);
      rd(5'd15, v); chk("unimpl_reg", v, 32'd0);

      mtc0(5'd12, 32'h0000_0101);
      mtc0(5'd13, 32'h0000_0300);
      chk("sw_int_pending", 32'(int_pending), 32'd1);
      rd(5'd13, v); chk("sw_cause", v, 32'h0000_0320);

      do_exc(5'd0, 32'h0000_0800, 1'b0, 32'd0);
      rst = 1'b1;
      #1 chk("rst_kills_pulse", 32'(redirect_valid), 32'd0);
      tick();
      chk("rst_next_cycle", 32'(redirect_valid), 32'd0);
      rst = 1'b0;
      rd(5'd12, v); chk("rst_mid_status", v, 32'h0040_0004);

      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
`ifdef CP0_TIMER_EN
      chk("timer_start", 32'(int_pending), 32'd0);
      cyc = 0;
      while (!int_pending && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("timer_cycles", 32'(cyc), 32'd10);
      rd(5'd9, v);  chk("timer_count", v, 32'd5);
      rd(5'd13, v); chk("timer_cause_ti", v, 32'h4000_8000);
      mtc0(5'd11, 32'd100);
      chk("timer_ti_clr_int", 32'(int_pending), 32'd0);
      rd(5'd13, v); chk("timer_ti_clr", v, 32'd0);
      rd(5'd11, v); chk("timer_compare", v, 32'd100);
`else
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (int_pending) seen = 1'b1;
      end
      chk("no_timer_int", 32'(seen), 32'd0);
      rd(5'd9, v);  chk("no_timer_count", v, 32'd0);
      rd(5'd11, v); chk("no_timer_compare", v, 32'd0);
      rd(5'd13, v); chk("no_timer_cause", v, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Clocked, parametrised MIPS coprocessor 0 for the pipelined CPU: holds Status, Cause, EPC, ErrorEPC, BadVAddr, Count and Compare, prioritises interrupts against precise exceptions and supplies the redirect PC for exception entry and `eret`. It sits beside the MEM stage: the pipeline reports exceptions and `eret` there and receives a one-cycle redirect pulse. Unlike the earlier combinational CP0, all state changes happen on the clock.

## Interface
- `HW_INT_W`, 6: number of hardware interrupt lines, legal range 1..6; drives Cause.IP[2+HW_INT_W-1:2].
- `EXC_VECTOR`, 32'h8000_0180: exception vector used when Status.BEV=0.
- `BEV_VECTOR`, 32'hBFC0_0380: exception vector used when Status.BEV=1.
- `COUNT_DIV`, 2: Count increments once every COUNT_DIV clocks; legal range ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `reg_num` in 5: CP0 register number for mfc0/mtc0.
- `reg_sel` in 3: select field; only sel 0 is implemented, so any other value reads 0 and ignores writes.
- `wdata` in 32: mtc0 write data.
- `we` in 1: mtc0 write strobe.
- `rdata` out 32: mfc0 read data, combinational.
- `hw_int` in HW_INT_W: level-sensitive hardware interrupt lines.
- `exc_req` in 1: precise exception committed this cycle.
- `exc_code` in 5: ExcCode for the exception; 0 means interrupt.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_bd` in 1: the faulting instruction is in a branch delay slot.
- `exc_badvaddr` in 32: faulting address, used only for codes 4 and 5.
- `eret` in 1: eret committed this cycle.
- `int_pending` out 1: an enabled interrupt is pending; combinational.
- `redirect_valid` out 1: one-cycle fetch redirect pulse.
- `redirect_pc` out 32: redirect target; valid only while `redirect_valid` is high.
- `status_exl` out 1: current value of Status.EXL.

## Operation
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 30 ErrorEPC. All other registers read 0 and ignore writes.
- Status writable bits: IE[0], EXL[1], ERL[2], UM[4], IM[15:8], BEV[22]. All other bits read 0.
- Cause writable bits: IP[9:8] (software interrupts) only. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are written only by hardware.
- Cause.IP[2+k] is set to `hw_int[k]` every cycle. IP[15] = hw_int[5] OR TI. IP bits above the configured HW_INT_W width read 0, except IP[15] which still carries TI.
- `int_pending` = IE & ~EXL & ~ERL & |(IP & IM). The pipeline responds by raising `exc_req` with `exc_code` = 0.
- Exception entry on `exc_req`:
  - If EXL=0: EPC ← (exc_bd ? exc_pc−4 : exc_pc) and BD ← exc_bd.
  - If EXL=1: EPC and BD are left unchanged.
  - In both cases ExcCode ← exc_code and EXL ← 1.
  - BadVAddr ← exc_badvaddr only when exc_code is 4 or 5.
  - Redirect target: BEV ? BEV_VECTOR : EXC_VECTOR.
- `eret` when ERL=1: ERL ← 0, redirect to ErrorEPC.
- `eret` when ERL=0: EXL ← 0, redirect to EPC.
- Priority within one cycle: `exc_req` wins over `eret`, and `eret` wins over `we`. The losing operation is discarded entirely.
- Timer (Count/Compare):
  - A prescaler counts 0..COUNT_DIV−1; Count increments and wraps 32'hFFFF_FFFF→0 when the prescaler wraps.
  - When the next Count value equals Compare, TI ← 1 (sticky).
  - An mtc0 to Compare clears TI; this clear takes priority over a simultaneous match.
  - An mtc0 to Count loads the value and resets the prescaler.

## Timing
- Reset values:
  - Status = 32'h0040_0004 (BEV=1, ERL=1).
  - Cause, EPC, ErrorEPC, BadVAddr, Count, Compare and the prescaler = 0.
  - `redirect_valid` = 0, `redirect_pc` = 0.
- All register updates occur on the rising edge. An mfc0 in cycle N+1 sees an mtc0 issued in cycle N; an mfc0 in the same cycle sees the old value.
- `redirect_valid`/`redirect_pc` are registered: an `exc_req`/`eret` in cycle N gives a pulse of exactly one cycle in N+1. The target is computed from register values in cycle N.
- `int_pending` reflects the registered IP/IM/IE state, so `hw_int` reaches it with 1 cycle latency.
- Back-to-back `exc_req` cycles are each processed; the nested case leaves EPC untouched.
- `rst` asserted mid-operation suppresses any redirect in that cycle and for the following cycle.

## Configuration
- `CP0_TIMER_EN` defined: Count, Compare, the prescaler and TI are implemented as described above.
- `CP0_TIMER_EN` undefined: registers 9 and 11 read 0 and ignore writes, TI is constant 0, and IP[15] = hw_int[5] (0 if HW_INT_W<6).

## Test plan
- Reset, then read reg 12 → 32'h0040_0004; write Status=32'h0000_0401 then read back → 32'h0000_0401.
- Status=32'h0000_0401 (IE, IM2), raise hw_int[0] → `int_pending`=1 one cycle later; then exc_req with code 0 and exc_pc=32'h8000_1000 → redirect_valid pulse with redirect_pc=32'h8000_0180, EPC=32'h8000_1000, Cause[6:2]=0, EXL=1, `int_pending`=0.
- exc_req with code 4, exc_bd=1, exc_pc=32'h100, badvaddr=32'h3 → EPC=32'hFC, Cause.BD=1, BadVAddr=32'h3; second exc_req while EXL=1 → EPC unchanged.
- With ERL=0, EXL=1: eret and we in the same cycle → redirect_pc=EPC, EXL=0, write dropped; with ERL=1, eret → redirect_pc=ErrorEPC and ERL cleared.
- COUNT_DIV=2, Count=0, Compare=5, IM7 and IE set → TI set and `int_pending`=1 when Count reaches 5 (≈10 cycles); then mtc0 Compare → TI=0.
- Build without `CP0_TIMER_EN`: reads of regs 9 and 11 → 0, and no timer interrupt after 100 cycles.
